// File: rtl/rib_arb_pkg.sv
// Shared definitions for the RIB bus arbiter: FSM encoding, bus widths and
// the position of the slave-select field within an address.
package rib_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_HI = 31;
  localparam int SEL_LO = 28;
  localparam int SEL_W  = SEL_HI - SEL_LO + 1;
  localparam int TMO_W  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Slaves see a local address: the select field is cleared.
  function automatic logic [ADDR_W-1:0] strip_sel(input logic [ADDR_W-1:0] addr);
    return {{SEL_W{1'b0}}, addr[SEL_LO-1:0]};
  endfunction

endpackage

// File: rtl/rib_arb_pick.sv
// Combinational winner selection: fixed priority order or round-robin
// starting at rr_ptr_i.
module rib_arb_pick
  import rib_arb_pkg::*;
#(
  parameter int NUM_M = 4,
  parameter int RR_MODE = 0,
  localparam int IDX_W = $clog2(NUM_M),
  parameter logic [NUM_M*IDX_W-1:0] PRIO_ORDER = {2'd3, 2'd0, 2'd2, 2'd1}
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             vld_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             fp_vld;
  logic [IDX_W-1:0] fp_idx;
  logic             rr_vld;
  logic [IDX_W-1:0] rr_idx;

  // Most significant field of PRIO_ORDER names the highest-priority master.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand   = '0;
    fp_vld = 1'b0;
    fp_idx = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      cand = PRIO_ORDER[i*IDX_W +: IDX_W];
      if (!fp_vld && (int'(cand) < NUM_M)) begin
        if (req_i[cand]) begin
          fp_vld = 1'b1;
          fp_idx = cand;
        end
      end
    end
  end

  always_comb begin
    int pos;
    pos    = 0;
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int off = 0; off < NUM_M; off++) begin
      pos = (int'(rr_ptr_i) + off) % NUM_M;
      if (!rr_vld && req_i[pos]) begin
        rr_vld = 1'b1;
        rr_idx = IDX_W'(pos);
      end
    end
  end

  assign vld_o = (RR_MODE != 0) ? rr_vld : fp_vld;
  assign idx_o = (RR_MODE != 0) ? rr_idx : fp_idx;

endmodule

// File: rtl/rib_arb.sv
// Multi-master to multi-slave RIB arbiter: one transaction at a time,
// slave chosen by addr[31:28], with decode-miss and timeout errors.
module rib_arb
  import rib_arb_pkg::*;
#(
  parameter int NUM_M = 4,
  parameter int NUM_S = 6,
  parameter int RR_MODE = 0,
  localparam int IDX_W = $clog2(NUM_M),
  parameter logic [NUM_M*IDX_W-1:0] PRIO_ORDER = {2'd3, 2'd0, 2'd2, 2'd1},
  parameter logic [NUM_M-1:0] HOLD_MASK = 4'b1101,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M-1:0]        m_req_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_M*DATA_W-1:0] m_data_i,
  output logic [NUM_M*DATA_W-1:0] m_data_o,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic [NUM_S-1:0]        s_req_o,
  output logic [NUM_S-1:0]        s_we_o,
  output logic [NUM_S*ADDR_W-1:0] s_addr_o,
  output logic [NUM_S*DATA_W-1:0] s_data_o,
  input  logic [NUM_S*DATA_W-1:0] s_data_i,
  input  logic [NUM_S-1:0]        s_ack_i,
  output logic                    hold_flag_o
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   rr_next;

  logic               g_we;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_data;
  logic [SEL_W-1:0]   sel;
  logic               hit;
  logic               tgt_ack;
  logic [DATA_W-1:0]  tgt_rdata;

  logic [NUM_M-1:0]        ack_vec, err_vec;
  logic [NUM_M*DATA_W-1:0] mdata_vec;
  logic [NUM_S-1:0]        sreq_vec, swe_vec;
  logic [NUM_S*ADDR_W-1:0] saddr_vec;
  logic [NUM_S*DATA_W-1:0] sdata_vec;

  rib_arb_pick #(
    .NUM_M      (NUM_M),
    .RR_MODE    (RR_MODE),
    .PRIO_ORDER (PRIO_ORDER)
  ) u_pick (
    .req_i    (m_req_i),
    .rr_ptr_i (rr_ptr_q),
    .vld_o    (pick_vld),
    .idx_o    (pick_idx)
  );

  // Granted master's request fields.
  always_comb begin
    g_we   = 1'b0;
    g_addr = '0;
    g_data = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt_q == IDX_W'(k)) begin
        g_we   = m_we_i[k];
        g_addr = m_addr_i[k*ADDR_W +: ADDR_W];
        g_data = m_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign sel = g_addr[SEL_HI:SEL_LO];
  assign hit = (int'(sel) < NUM_S);

  always_comb begin
    tgt_ack   = 1'b0;
    tgt_rdata = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (int'(sel) == s) begin
        tgt_ack   = s_ack_i[s];
        tgt_rdata = s_data_i[s*DATA_W +: DATA_W];
      end
    end
  end

  assign rr_next = (gnt_q == IDX_W'(NUM_M - 1)) ? '0 : gnt_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_d     = tmo_q;
    ack_vec   = '0;
    err_vec   = '0;
    mdata_vec = '0;
    sreq_vec  = '0;
    swe_vec   = '0;
    saddr_vec = '0;
    sdata_vec = '0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (pick_vld) begin
          gnt_d   = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!hit) begin
          err_vec[gnt_q] = 1'b1;
          state_d        = ST_IDLE;
          tmo_d          = '0;
          rr_ptr_d       = rr_next;
        end else begin
          for (int s = 0; s < NUM_S; s++) begin
            if (int'(sel) == s) begin
              sreq_vec[s]                    = 1'b1;
              swe_vec[s]                     = g_we;
              saddr_vec[s*ADDR_W +: ADDR_W]  = strip_sel(g_addr);
              sdata_vec[s*DATA_W +: DATA_W]  = g_data;
            end
          end
          // An ack in the same cycle the count expires still wins.
          if (tgt_ack) begin
            ack_vec[gnt_q]                     = 1'b1;
            mdata_vec[gnt_q*DATA_W +: DATA_W]  = tgt_rdata;
            state_d                            = ST_IDLE;
            tmo_d                              = '0;
            rr_ptr_d                           = rr_next;
          end else if (tmo_q == TMO_W'(TIMEOUT)) begin
            err_vec[gnt_q] = 1'b1;
            state_d        = ST_IDLE;
            tmo_d          = '0;
            rr_ptr_d       = rr_next;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      tmo_q    <= tmo_d;
    end
  end

  // Strobes are masked while rst is high so an aborted transfer stays silent.
  assign m_ack_o  = rst ? '0 : ack_vec;
  assign m_err_o  = rst ? '0 : err_vec;
  assign m_data_o = rst ? '0 : mdata_vec;
  assign s_req_o  = rst ? '0 : sreq_vec;
  assign s_we_o   = rst ? '0 : swe_vec;
  assign s_addr_o = saddr_vec;
  assign s_data_o = sdata_vec;

  assign hold_flag_o = |(m_req_i & HOLD_MASK);

endmodule

// File: tb/tb_rib_arb.sv
// Directed bench for rib_arb: a fixed-priority instance (TIMEOUT=4) and a
// round-robin instance share master stimulus; each has its own slave model.
module tb_rib_arb;

  localparam int NUM_M = 4;
  localparam int NUM_S = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_M-1:0]     m_req = '0;
  logic [NUM_M-1:0]     m_we = '0;
  logic [NUM_M*32-1:0]  m_addr = '0;
  logic [NUM_M*32-1:0]  m_wdata = '0;
  logic [NUM_S*32-1:0]  s_rdata = '0;
  logic                 ack_en = 1'b1;

  logic [NUM_M*32-1:0]  fp_m_rdata, rr_m_rdata;
  logic [NUM_M-1:0]     fp_m_ack, fp_m_err, rr_m_ack, rr_m_err;
  logic [NUM_S-1:0]     fp_s_req, fp_s_we, fp_s_ack, rr_s_req, rr_s_we, rr_s_ack;
  logic [NUM_S*32-1:0]  fp_s_addr, fp_s_wdata, rr_s_addr, rr_s_wdata;
  logic                 fp_hold, rr_hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Zero-wait slaves when ack_en is set, silent slaves otherwise.
  assign fp_s_ack = fp_s_req & {NUM_S{ack_en}};
  assign rr_s_ack = rr_s_req & {NUM_S{ack_en}};

  rib_arb #(.NUM_M(NUM_M), .NUM_S(NUM_S), .RR_MODE(0), .TIMEOUT(4)) dut_fp (
    .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
    .m_data_i(m_wdata), .m_data_o(fp_m_rdata), .m_ack_o(fp_m_ack), .m_err_o(fp_m_err),
    .s_req_o(fp_s_req), .s_we_o(fp_s_we), .s_addr_o(fp_s_addr), .s_data_o(fp_s_wdata),
    .s_data_i(s_rdata), .s_ack_i(fp_s_ack), .hold_flag_o(fp_hold)
  );

  rib_arb #(.NUM_M(NUM_M), .NUM_S(NUM_S), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
    .m_data_i(m_wdata), .m_data_o(rr_m_rdata), .m_ack_o(rr_m_ack), .m_err_o(rr_m_err),
    .s_req_o(rr_s_req), .s_we_o(rr_s_we), .s_addr_o(rr_s_addr), .s_data_o(rr_s_wdata),
    .s_data_i(s_rdata), .s_ack_i(rr_s_ack), .hold_flag_o(rr_hold)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; m_req = '0; m_we = '0; ack_en = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_req = 4'b1111; m_addr = '0;
    step();
    @(negedge clk);
    checks++; if (fp_s_req !== 6'b0) begin errors++; $display("FAIL rst_fp_sreq got %b want 000000", fp_s_req); end
    checks++; if (fp_m_ack !== 4'b0) begin errors++; $display("FAIL rst_fp_ack got %b want 0000", fp_m_ack); end
    checks++; if (rr_m_err !== 4'b0) begin errors++; $display("FAIL rst_rr_err got %b want 0000", rr_m_err); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (fp_s_req !== 6'b0) begin errors++; $display("FAIL post_rst_fp_sreq got %b want 000000", fp_s_req); end
    checks++; if (rr_m_ack !== 4'b0) begin errors++; $display("FAIL post_rst_rr_ack got %b want 0000", rr_m_ack); end
    checks++; if (fp_m_err !== 4'b0) begin errors++; $display("FAIL post_rst_fp_err got %b want 0000", fp_m_err); end
    checks++; if (fp_hold !== 1'b1) begin errors++; $display("FAIL hold_1111 got %b want 1", fp_hold); end
    m_req = 4'b0010; #1;
    checks++; if (fp_hold !== 1'b0) begin errors++; $display("FAIL hold_0010 got %b want 0", fp_hold); end
    m_req = 4'b1000; #1;
    checks++; if (rr_hold !== 1'b1) begin errors++; $display("FAIL hold_1000 got %b want 1", rr_hold); end
    m_req = 4'b0100; #1;
    checks++; if (fp_hold !== 1'b1) begin errors++; $display("FAIL hold_0100 got %b want 1", fp_hold); end
    m_req = '0;
    do_reset();
  endtask

  task automatic test_fixed_prio();
    int order[4] = '{3, 0, 2, 1};
    logic [3:0] exp, seen;
    do_reset();
    for (int k = 0; k < NUM_M; k++) m_addr[k*32 +: 32] = 32'h1000_0000 | 32'(k << 4);
    m_req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp = (c % 2 == 1) ? (4'(1) << order[c/2]) : 4'b0;
      checks++; if (fp_m_ack !== exp) begin errors++; $display("FAIL fp_prio_ack c%0d got %b want %b", c, fp_m_ack, exp); end
      if (c % 2 == 1) begin
        checks++; if (fp_m_rdata[order[c/2]*32 +: 32] !== 32'hC0DE_0001) begin errors++; $display("FAIL fp_prio_rdata c%0d got %h want c0de0001", c, fp_m_rdata[order[c/2]*32 +: 32]); end
        checks++; if (fp_s_req !== 6'b000010) begin errors++; $display("FAIL fp_prio_sreq c%0d got %b want 000010", c, fp_s_req); end
      end
      seen = fp_m_ack | fp_m_err;
      step();
      m_req = m_req & ~seen;
    end
    m_req = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    logic [NUM_M*32-1:0] exp_data;
    do_reset();
    m_addr = '0;
    m_req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp = (c % 2 == 1) ? (4'(1) << ((c / 2) % 4)) : 4'b0;
      exp_data = '0;
      if (c % 2 == 1) exp_data[((c / 2) % 4)*32 +: 32] = 32'hC0DE_0000;
      checks++; if (rr_m_ack !== exp) begin errors++; $display("FAIL rr_ack c%0d got %b want %b", c, rr_m_ack, exp); end
      checks++; if (rr_m_rdata !== exp_data) begin errors++; $display("FAIL rr_rdata c%0d got %h want %h", c, rr_m_rdata, exp_data); end
      step();
    end
    m_req = '0;
  endtask

  task automatic test_read();
    do_reset();
    s_rdata[63:32] = 32'hDEAD_BEEF;
    m_addr[31:0] = 32'h1000_0010;
    m_req = 4'b0001;
    @(negedge clk);
    checks++; if (fp_s_req !== 6'b0) begin errors++; $display("FAIL rd_idle_sreq got %b want 000000", fp_s_req); end
    step();
    @(negedge clk);
    checks++; if (fp_s_req !== 6'b000010) begin errors++; $display("FAIL rd_sreq got %b want 000010", fp_s_req); end
    checks++; if (fp_s_addr[63:32] !== 32'h0000_0010) begin errors++; $display("FAIL rd_saddr got %h want 00000010", fp_s_addr[63:32]); end
    checks++; if (fp_s_we !== 6'b0) begin errors++; $display("FAIL rd_swe got %b want 000000", fp_s_we); end
    checks++; if (fp_m_ack !== 4'b0001) begin errors++; $display("FAIL rd_ack got %b want 0001", fp_m_ack); end
    checks++; if (fp_m_rdata !== {96'b0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL rd_mdata got %h want deadbeef in lane 0", fp_m_rdata); end
    step();
    m_req = '0;
    @(negedge clk);
    checks++; if (fp_m_ack !== 4'b0) begin errors++; $display("FAIL rd_after_ack got %b want 0000", fp_m_ack); end
    checks++; if (fp_m_rdata !== '0) begin errors++; $display("FAIL rd_after_mdata got %h want 0", fp_m_rdata); end
    s_rdata[63:32] = 32'hC0DE_0001;
  endtask

  task automatic test_write();
    do_reset();
    m_addr[63:32] = 32'h2ABC_0004;
    m_wdata[63:32] = 32'h1234_5678;
    m_we = 4'b0010;
    m_req = 4'b0010;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (fp_s_req !== 6'b000100) begin errors++; $display("FAIL wr_sreq got %b want 000100", fp_s_req); end
    checks++; if (fp_s_we !== 6'b000100) begin errors++; $display("FAIL wr_swe got %b want 000100", fp_s_we); end
    checks++; if (fp_s_addr[95:64] !== 32'h0ABC_0004) begin errors++; $display("FAIL wr_saddr got %h want 0abc0004", fp_s_addr[95:64]); end
    checks++; if (fp_s_wdata[95:64] !== 32'h1234_5678) begin errors++; $display("FAIL wr_sdata got %h want 12345678", fp_s_wdata[95:64]); end
    checks++; if (fp_s_addr[63:32] !== 32'h0) begin errors++; $display("FAIL wr_other_saddr got %h want 0", fp_s_addr[63:32]); end
    checks++; if (fp_m_ack !== 4'b0010) begin errors++; $display("FAIL wr_ack got %b want 0010", fp_m_ack); end
    checks++; if (rr_s_we !== 6'b000100) begin errors++; $display("FAIL wr_rr_swe got %b want 000100", rr_s_we); end
    checks++; if (rr_s_addr[95:64] !== 32'h0ABC_0004) begin errors++; $display("FAIL wr_rr_saddr got %h want 0abc0004", rr_s_addr[95:64]); end
    checks++; if (rr_s_wdata[95:64] !== 32'h1234_5678) begin errors++; $display("FAIL wr_rr_sdata got %h want 12345678", rr_s_wdata[95:64]); end
    step();
    m_req = '0; m_we = '0;
  endtask

  task automatic test_decode_err();
    do_reset();
    m_addr[95:64] = 32'h7000_0000;
    m_req = 4'b0100;
    @(negedge clk);
    checks++; if (fp_m_err !== 4'b0) begin errors++; $display("FAIL dec_idle_err got %b want 0000", fp_m_err); end
    step();
    @(negedge clk);
    checks++; if (fp_s_req !== 6'b0) begin errors++; $display("FAIL dec_sreq got %b want 000000", fp_s_req); end
    checks++; if (fp_m_err !== 4'b0100) begin errors++; $display("FAIL dec_err got %b want 0100", fp_m_err); end
    checks++; if (fp_m_ack !== 4'b0) begin errors++; $display("FAIL dec_ack got %b want 0000", fp_m_ack); end
    checks++; if (rr_m_err !== 4'b0100) begin errors++; $display("FAIL dec_rr_err got %b want 0100", rr_m_err); end
    step();
    m_req = '0;
    @(negedge clk);
    checks++; if (fp_m_err !== 4'b0) begin errors++; $display("FAIL dec_after_err got %b want 0000", fp_m_err); end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_err, seen;
    logic [5:0] exp_sreq;
    do_reset();
    ack_en = 1'b0;
    m_addr[63:32] = 32'h0000_0040;
    m_req = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      exp_err  = (c == 5) ? 4'b0010 : 4'b0;
      exp_sreq = (c >= 1 && c <= 5) ? 6'b000001 : 6'b0;
      checks++; if (fp_m_err !== exp_err) begin errors++; $display("FAIL tmo_err c%0d got %b want %b", c, fp_m_err, exp_err); end
      checks++; if (fp_s_req !== exp_sreq) begin errors++; $display("FAIL tmo_sreq c%0d got %b want %b", c, fp_s_req, exp_sreq); end
      seen = fp_m_err | fp_m_ack;
      step();
      m_req = m_req & ~seen;
    end
    m_req = '0;
    ack_en = 1'b1;
  endtask

  task automatic test_rst_busy();
    do_reset();
    m_addr = '0;
    m_req = 4'b0100;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (rr_m_ack !== 4'b0100) begin errors++; $display("FAIL rb_first_ack got %b want 0100", rr_m_ack); end
    step();
    m_req = 4'b0010; ack_en = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (rr_s_req !== 6'b000001) begin errors++; $display("FAIL rb_busy_sreq got %b want 000001", rr_s_req); end
    step();
    rst = 1'b1; ack_en = 1'b1;
    @(negedge clk);
    checks++; if (rr_s_req !== 6'b0) begin errors++; $display("FAIL rb_rst_sreq got %b want 000000", rr_s_req); end
    checks++; if (rr_m_ack !== 4'b0) begin errors++; $display("FAIL rb_rst_ack got %b want 0000", rr_m_ack); end
    checks++; if (rr_m_err !== 4'b0) begin errors++; $display("FAIL rb_rst_err got %b want 0000", rr_m_err); end
    step();
    rst = 1'b0; m_req = 4'b1010;
    @(negedge clk);
    checks++; if (rr_s_req !== 6'b0) begin errors++; $display("FAIL rb_idle_sreq got %b want 000000", rr_s_req); end
    checks++; if (rr_m_ack !== 4'b0) begin errors++; $display("FAIL rb_idle_ack got %b want 0000", rr_m_ack); end
    step();
    @(negedge clk);
    checks++; if (rr_m_ack !== 4'b0010) begin errors++; $display("FAIL rb_ptr_ack got %b want 0010", rr_m_ack); end
    step();
    m_req = '0;
  endtask

  initial begin
    for (int s = 0; s < NUM_S; s++) s_rdata[s*32 +: 32] = 32'hC0DE_0000 + 32'(s);
    test_reset();
    test_fixed_prio();
    test_round_robin();
    test_read();
    test_write();
    test_decode_err();
    test_timeout();
    test_rst_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rib_arb.md
RIB_ARB -- requirements
Module: rib_arb

Interface
REQ-001 SHALL have parameter NUM_M, default 4, number of masters (2..8).
REQ-002 SHALL have parameter NUM_S, default 6, number of slaves (1..16).
REQ-003 SHALL have parameter RR_MODE, default 0: 0 = fixed priority, 1 = round-robin.
REQ-004 SHALL have parameter PRIO_ORDER, default {3,0,2,1} packed as 2-bit fields, MSB field highest; used only when RR_MODE=0 (generalises to NUM_M fields of $clog2(NUM_M) bits).
REQ-005 SHALL have parameter HOLD_MASK, default 4'b1101, masters whose request stalls the pipeline.
REQ-006 SHALL have parameter TIMEOUT, default 255, maximum BUSY cycles before error (1..65535).
REQ-007 SHALL have one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-008 clk  in  1  clock, all state updates on rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 m_req_i  in  NUM_M  per-master request, held until its m_ack_o or m_err_o.
REQ-011 m_we_i  in  NUM_M  per-master write flag.
REQ-012 m_addr_i  in  NUM_M*32  per-master address, master k at bits [32k+31:32k].
REQ-013 m_data_i  in  NUM_M*32  per-master write data.
REQ-014 m_data_o  out  NUM_M*32  per-master read data.
REQ-015 m_ack_o  out  NUM_M  one-cycle completion pulse.
REQ-016 m_err_o  out  NUM_M  one-cycle error pulse (decode miss or timeout).
REQ-017 s_req_o  out  NUM_S  per-slave access strobe.
REQ-018 s_we_o  out  NUM_S  per-slave write flag.
REQ-019 s_addr_o  out  NUM_S*32  per-slave address, top 4 bits forced to 0.
REQ-020 s_data_o  out  NUM_S*32  per-slave write data.
REQ-021 s_data_i  in  NUM_S*32  per-slave read data.
REQ-022 s_ack_i  in  NUM_S  per-slave completion, may be same cycle as s_req_o.
REQ-023 hold_flag_o  out  1  pipeline stall request.

Function
REQ-024 SHALL implement states IDLE and BUSY.
REQ-025 IDLE: if any m_req_i, latch winner index into grant register and go BUSY next cycle; else stay IDLE.
REQ-026 RR_MODE=0: winner = first requesting master in PRIO_ORDER.
REQ-027 RR_MODE=1: winner = first requesting master at or after rr_ptr, wrapping modulo NUM_M; rr_ptr = winner+1 mod NUM_M on completion or error.
REQ-028 BUSY: slave index = granted addr[31:28]; if index < NUM_S, drive that slave's s_req_o=1, s_we_o, s_addr_o, s_data_o from granted master; all other slave outputs 0.
REQ-029 BUSY with s_ack_i of target: m_ack_o[grant]=1 and m_data_o[grant]=target s_data_i same cycle; next state IDLE.
REQ-030 BUSY with index >= NUM_S: no s_req_o, m_err_o[grant]=1 in first BUSY cycle, next state IDLE.
REQ-031 BUSY timeout counter starts at 0 on entry, increments per cycle; when it reaches TIMEOUT without ack, m_err_o[grant]=1, next IDLE, counter cleared.
REQ-032 Minimum latency request->ack: 2 cycles (arbitration + zero-wait slave); one IDLE cycle between back-to-back grants.
REQ-033 Requests arriving during BUSY SHALL wait; grant SHALL NOT change in BUSY.
REQ-034 Granted master dropping m_req_i in BUSY: transaction still completes normally.
REQ-035 m_data_o of non-granted masters SHALL be 0; granted master with no ack SHALL see 0.
REQ-036 hold_flag_o SHALL be combinational |(m_req_i & HOLD_MASK).

Reset
REQ-037 On rst: state=IDLE, grant=0, rr_ptr=0, timeout counter=0.
REQ-038 During and one cycle after rst: all s_req_o, m_ack_o, m_err_o = 0.
REQ-039 rst mid-BUSY SHALL abort silently: no ack or error pulse emitted.

Structure
REQ-040 Shared package SHALL hold state encoding, slave-select field position [31:28], and data/address width constants.
REQ-041 One sub-module rib_arb_pick SHALL compute winner index from requests, mode, order and rr_ptr (combinational).

Verification
REQ-042 RR_MODE=0, m0..m3 req all at once -> grants in order m3, m0, m2, m1, each ack 2 cycles after grant with zero-wait slave.
REQ-043 RR_MODE=1, all 4 requesting continuously -> grants 0,1,2,3,0; no starvation.
REQ-044 m0 reads addr 0x1000_0010, slave1 returns 0xDEAD_BEEF -> s1_addr_o=0x0000_0010, m_data_o[0]=0xDEAD_BEEF with m_ack_o[0].
REQ-045 m2 accesses 0x7000_0000 (NUM_S=6) -> m_err_o[2] pulse, no s_req_o asserted.
REQ-046 TIMEOUT=4, slave never acks -> m_err_o pulse exactly 4 cycles after BUSY entry.
REQ-047 rst asserted in BUSY cycle 2 -> IDLE next cycle, no ack/err, rr_ptr=0.
